// File: rtl/nonce_arbiter_if.sv
// Bundle between the hasher cores / serial transmitter side and the nonce arbiter.
// The cores and transmitter use the master modport; the arbiter uses the slave modport.
interface nonce_arbiter_if #(
  parameter int SLAVES = 2
);
  logic [SLAVES-1:0]    new_nonces;
  logic [32*SLAVES-1:0] slave_nonces;
  logic                 serial_busy;
  logic                 serial_send;
  logic [31:0]          golden_nonce;
  logic [SLAVES-1:0]    pending;
  logic                 fifo_full;
  logic [7:0]           dropped_count;

  modport master (
    output new_nonces, slave_nonces, serial_busy,
    input  serial_send, golden_nonce, pending, fifo_full, dropped_count
  );

  modport slave (
    input  new_nonces, slave_nonces, serial_busy,
    output serial_send, golden_nonce, pending, fifo_full, dropped_count
  );
endinterface

// File: rtl/nonce_arbiter.sv
// Captures golden-nonce tickets per core, moves them round-robin into a small FWFT FIFO,
// and feeds the serial transmitter one word at a time.
module nonce_arbiter #(
  parameter int SLAVES       = 2,
  parameter int FIFO_ABITS   = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic          hash_clk,
  input  logic          reset,
  nonce_arbiter_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_ABITS;
  localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} tx_state_t;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= SLAVES) s = s - SLAVES;
    return PTR_W'(s);
  endfunction

  logic [31:0]          holding [SLAVES];
  logic [SLAVES-1:0]    pending_q;
  logic [7:0]           dropped_q;
  logic [7:0]           dropped_next;
  logic [SLAVES-1:0]    drop_vec;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant;
  logic                 grant_valid;
  logic                 push;
  logic                 pop;

  logic [31:0]          mem [DEPTH];
  logic [FIFO_ABITS-1:0] wr_ptr;
  logic [FIFO_ABITS-1:0] rd_ptr;
  logic [FIFO_ABITS:0]  count;
  logic                 fifo_empty;
  logic                 full;

  tx_state_t            state;
  tx_state_t            state_next;
  logic [TO_W-1:0]      to_cnt;
  logic                 serial_send_q;
  logic [31:0]          golden_q;

  assign fifo_empty = (count == '0);
  assign full       = (count == (FIFO_ABITS + 1)'(DEPTH));

  // Round-robin search: first pending slave at or above rr_ptr, wrapping.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < SLAVES; off++) begin
      if (!grant_valid && pending_q[wrap_add(rr_ptr, off)]) begin
        grant       = wrap_add(rr_ptr, off);
        grant_valid = 1'b1;
      end
    end
  end

  assign pop  = (state == IDLE) && !fifo_empty && !bus.serial_busy;
  assign push = grant_valid && (!full || pop);

  // A new ticket landing on an occupied, ungranted register loses the older nonce.
  always_comb begin
    logic [8:0] drop_sum;
    drop_vec = '0;
    drop_sum = 9'(dropped_q);
    for (int i = 0; i < SLAVES; i++) begin
      drop_vec[i] = bus.new_nonces[i] && pending_q[i] && !(push && (grant == PTR_W'(i)));
      drop_sum    = drop_sum + 9'(drop_vec[i]);
    end
    dropped_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      pending_q <= '0;
      dropped_q <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (bus.new_nonces[i])
          pending_q[i] <= 1'b1;
        else if (push && (grant == PTR_W'(i)))
          pending_q[i] <= 1'b0;
      end
      dropped_q <= dropped_next;
      if (push) rr_ptr <= wrap_add(grant, 1);
    end
  end

  // NOTE: data-only storage carries no reset; pending bits and FIFO pointers decide validity.
  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < SLAVES; i++) begin
      if (bus.new_nonces[i]) holding[i] <= bus.slave_nonces[32*i +: 32];
    end
    if (push) mem[wr_ptr] <= holding[grant];
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state         <= IDLE;
      to_cnt        <= '0;
      serial_send_q <= 1'b0;
      golden_q      <= '0;
    end else begin
      state         <= state_next;
      serial_send_q <= (state == SEND);
      if (pop) golden_q <= mem[rd_ptr];
      if (state == WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
      else                    to_cnt <= '0;
    end
  end

  // The send strobe is registered off SEND, so golden_nonce leads it by one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = SEND;
      SEND:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.serial_busy)                          state_next = WAIT_DONE;
        else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1))   state_next = IDLE;
      end
      WAIT_DONE: if (!bus.serial_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign bus.serial_send   = serial_send_q;
  assign bus.golden_nonce  = golden_q;
  assign bus.pending       = pending_q;
  assign bus.fifo_full     = full;
  assign bus.dropped_count = dropped_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// Directed bench for nonce_arbiter: expected words are queued at stimulus time and
// compared by a monitor whenever serial_send fires.
module tb_nonce_arbiter;

  logic hash_clk = 1'b0;
  logic reset    = 1'b1;

  nonce_arbiter_if #(.SLAVES(2)) bus ();

  nonce_arbiter #(.SLAVES(2), .FIFO_ABITS(2), .BUSY_TIMEOUT(8)) dut (
    .hash_clk (hash_clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 hash_clk = ~hash_clk;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  int          send_cnt = 0;
  int          send_cyc [$];
  logic [31:0] exp_q [$];
  logic [31:0] prev_golden = '0;

  // Transmitter model: busy rises at the negedge that sees the send strobe.
  logic        hold_busy = 1'b0;
  logic        respond   = 1'b1;
  int          busy_len  = 20;
  int          tx_left   = 0;

  assign bus.serial_busy = hold_busy | (tx_left != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge hash_clk) begin
    cyc++;
    if (tx_left > 0) tx_left--;
    if (bus.serial_send === 1'b1) begin
      send_cnt++;
      send_cyc.push_back(cyc);
      if (respond) tx_left = busy_len;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_send: got 0x%08h expected no send", bus.golden_nonce);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("send_word", bus.golden_nonce, e);
        check("golden_early", prev_golden, e);
      end
    end
    prev_golden = bus.golden_nonce;
  end

  task automatic pulse(input logic [1:0] mask, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge hash_clk);
    bus.new_nonces   = mask;
    bus.slave_nonces = {d1, d0};
    @(negedge hash_clk);
    bus.new_nonces   = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge hash_clk);
    reset = 1'b1;
    @(negedge hash_clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge hash_clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (busy_len + 12) @(negedge hash_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.new_nonces   = '0;
    bus.slave_nonces = '0;
    repeat (3) @(negedge hash_clk);
    reset = 1'b0;

    check("rst_send",    32'(bus.serial_send),   32'd0);
    check("rst_golden",  bus.golden_nonce,       32'd0);
    check("rst_pending", 32'(bus.pending),       32'd0);
    check("rst_full",    32'(bus.fifo_full),     32'd0);
    check("rst_dropped", 32'(bus.dropped_count), 32'd0);

    // Single nonce: latency k+2 for golden_nonce, k+3 for the strobe.
    busy_len = 20;
    base = send_cnt;
    exp_q.push_back(32'h1234_5678);
    pulse(2'b01, 32'h1234_5678, 32'h0);
    @(negedge hash_clk);
    @(negedge hash_clk);
    check("lat_golden_k2", bus.golden_nonce, 32'h1234_5678);
    check("lat_nosend_k2", 32'(bus.serial_send), 32'd0);
    @(negedge hash_clk);
    check("lat_send_k3", 32'(bus.serial_send), 32'd1);
    drain("single_drain", 60);
    check("single_one_pulse", 32'(send_cnt - base), 32'd1);
    check("single_dropped", 32'(bus.dropped_count), 32'd0);

    // Simultaneous tickets, rr_ptr = 0: slave0 first.
    busy_len = 3;
    do_reset();
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    pulse(2'b11, 32'hA, 32'hB);
    drain("simul_rr0_drain", 80);

    // Advance rr_ptr to 1 with a lone slave0 nonce, then slave1 goes first.
    exp_q.push_back(32'hC);
    pulse(2'b01, 32'hC, 32'h0);
    drain("simul_prep_drain", 80);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hA);
    pulse(2'b11, 32'hA, 32'hB);
    drain("simul_rr1_drain", 80);

    // Overflow: FIFO fills with 1..4, 5 is overwritten by 6.
    do_reset();
    hold_busy = 1'b1;
    for (int v = 1; v <= 6; v++) pulse(2'b01, 32'(v), 32'h0);
    repeat (2) @(negedge hash_clk);
    check("ovf_full",    32'(bus.fifo_full),     32'd1);
    check("ovf_pending", 32'(bus.pending),       32'd1);
    check("ovf_dropped", 32'(bus.dropped_count), 32'd1);
    for (int v = 1; v <= 4; v++) exp_q.push_back(32'(v));
    exp_q.push_back(32'd6);
    hold_busy = 1'b0;
    drain("ovf_drain", 200);
    check("ovf_dropped_end", 32'(bus.dropped_count), 32'd1);
    check("ovf_pending_end", 32'(bus.pending),       32'd0);

    // Grant collision: new ticket on slave0 in the cycle its old value is granted.
    do_reset();
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    @(negedge hash_clk);
    bus.new_nonces   = 2'b01;
    bus.slave_nonces = {32'h0, 32'h11};
    @(negedge hash_clk);
    bus.slave_nonces = {32'h0, 32'h22};
    @(negedge hash_clk);
    bus.new_nonces   = 2'b00;
    check("coll_pending", 32'(bus.pending),       32'd1);
    check("coll_dropped", 32'(bus.dropped_count), 32'd0);
    drain("coll_drain", 80);
    check("coll_dropped_end", 32'(bus.dropped_count), 32'd0);

    // Busy timeout: transmitter never answers; sends are 10 cycles apart.
    do_reset();
    respond = 1'b0;
    send_cyc.delete();
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h66);
    pulse(2'b11, 32'h55, 32'h66);
    drain("timeout_drain", 80);
    check("timeout_nsends", 32'(send_cyc.size()), 32'd2);
    if (send_cyc.size() == 2)
      check("timeout_gap", 32'(send_cyc[1] - send_cyc[0]), 32'd10);
    respond = 1'b1;

    // Reset mid-stream: A1 in flight (WAIT_DONE), B1/C1/D1 queued, then flushed.
    do_reset();
    busy_len = 40;
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hB1);
    exp_q.push_back(32'hC1);
    exp_q.push_back(32'hD1);
    pulse(2'b11, 32'hA1, 32'hB1);
    pulse(2'b11, 32'hC1, 32'hD1);
    repeat (6) @(negedge hash_clk);
    check("mid_first_sent", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    base = send_cnt;
    do_reset();
    check("mid_send",    32'(bus.serial_send),   32'd0);
    check("mid_pending", 32'(bus.pending),       32'd0);
    check("mid_full",    32'(bus.fifo_full),     32'd0);
    check("mid_dropped", 32'(bus.dropped_count), 32'd0);
    check("mid_golden",  bus.golden_nonce,       32'd0);
    repeat (80) @(negedge hash_clk);
    check("mid_no_sends", 32'(send_cnt - base), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
